// File: rtl/shift_add_binary_multiplier_pkg.sv
// rtl/shift_add_binary_multiplier_pkg.sv - shared state type and width helper for the shift-add multiplier
package shift_add_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_binary_multiplier_if.sv
// rtl/shift_add_binary_multiplier_if.sv - operand/product bundle for the shift-add multiplier
interface shift_add_if #(
  parameter int m = 4,
  parameter int n = 4
);
  logic [m-1:0]   A;
  logic [n-1:0]   B;
  logic [m+n-1:0] C;

  modport master (output A, output B, input C);
  modport slave  (input A, input B, output C);
endinterface

// File: rtl/shift_add_binary_multiplier_datapath.sv
// rtl/shift_add_binary_multiplier_datapath.sv - multiplicand, accumulator, adder and multiplier shift register
// Optional SHIFT_ADD_EARLY_TERM_EN: tracks the unshifted multiplier bits to flag early completion.
module shift_add_datapath #(
  parameter int m = 4,
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [m-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [m+n-1:0] prod_next,
  output logic           rest_zero
);

  logic [m-1:0]   mcand;
  logic [m:0]     acc;
  logic [n-1:0]   mplier;
  logic [m:0]     sum;
  logic [m+n:0]   shifted;

  // acc[m] is always zero after a shift, so the add can never lose a carry
  always_comb begin
    sum       = acc + (mplier[0] ? {1'b0, mcand} : '0);
    shifted   = {sum, mplier} >> 1;
    prod_next = shifted[m+n-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand  <= a;
      acc    <= '0;
      mplier <= b;
    end else if (step) begin
      acc    <= shifted[m+n:n];
      mplier <= shifted[n-1:0];
    end
  end

`ifdef SHIFT_ADD_EARLY_TERM_EN
  logic [n-1:0] rem;

  // rem holds the multiplier bits not yet consumed, current bit in rem[0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rem <= '0;
    else if (load) rem <= b;
    else if (step) rem <= rem >> 1;
  end

  assign rest_zero = (rem >> 1) == '0;
`else
  assign rest_zero = 1'b0;
`endif

endmodule

// File: rtl/shift_add_binary_multiplier.sv
// rtl/shift_add_binary_multiplier.sv - sequential shift-and-add unsigned multiplier, one bit per clock
// Optional SHIFT_ADD_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_binary_multiplier
  import shift_add_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [m-1:0]   A,
  input  logic [n-1:0]   B,
  output logic [m+n-1:0] C
);

  localparam int             cw       = cnt_width(n);
  localparam logic [cw-1:0]  last_cnt = cw'(n - 1);

  state_t         state, state_n;
  logic [cw-1:0]  count;
  logic           load, step, finish, rest_zero;
  logic [m+n-1:0] prod_next, aligned;

  shift_add_datapath #(.m(m), .n(n)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a         (A),
    .b         (B),
    .prod_next (prod_next),
    .rest_zero (rest_zero)
  );

  // an early finish still owes (last_cnt - count) shifts; on the final step this is zero
  assign aligned = prod_next >> (last_cnt - count);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      LOAD: begin
        load    = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (count == last_cnt || rest_zero) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      count <= '0;
      C     <= '0;
    end else begin
      state <= state_n;
      if (load)      count <= '0;
      else if (step) count <= count + 1'b1;
      if (finish)    C <= aligned;
    end
  end

endmodule

// File: tb/tb_shift_add_binary_multiplier.sv
// tb/tb_shift_add_binary_multiplier.sv - directed-vector self-checking bench for the shift-add multiplier
module tb_shift_add_binary_multiplier;
  import shift_add_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  shift_add_if #(.m(4), .n(4)) bus ();

  shift_add_binary_multiplier #(.m(4), .n(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (bus.A),
    .B   (bus.B),
    .C   (bus.C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int latency(input logic [3:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 4; i++) if (b[i]) hi = i + 1;
    return 1 + ((hi == 0) ? 1 : hi);
`else
    return 5;
`endif
  endfunction

  task automatic mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    int lat;
    lat = latency(b);
    @(negedge clk);
    rst   = 1'b1;
    bus.A = a;
    bus.B = b;
    #1;
    check({tag, " reset C"}, 32'(bus.C), 32'd0);
    check({tag, " reset state"}, 32'(dut.state), 32'(LOAD));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        bus.A = ~a;
        bus.B = ~b;
      end
      if (k < lat) check($sformatf("%s C edge %0d", tag, k), 32'(bus.C), 32'd0);
      else         check($sformatf("%s C edge %0d", tag, k), 32'(bus.C), 32'(exp));
    end
    check({tag, " done state"}, 32'(dut.state), 32'(DONE));
    bus.A = 4'd7;
    bus.B = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold C"}, 32'(bus.C), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.A    = '0;
    bus.B    = '0;
    repeat (2) @(negedge clk);

    mult(4'b1111, 4'b1111, 8'd225, "15x15");
    mult(4'b0011, 4'b0011, 8'd9,   "3x3");
    mult(4'b1101, 4'b0010, 8'd26,  "13x2");
    mult(4'b1010, 4'b0000, 8'd0,   "10x0");
    mult(4'b0000, 4'b1111, 8'd0,   "0x15");
    mult(4'b0001, 4'b1000, 8'd8,   "1x8");

    // abort 15x15 after the LOAD edge and two CALC edges
    @(negedge clk);
    rst   = 1'b1;
    bus.A = 4'b1111;
    bus.B = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort pre C", 32'(bus.C), 32'd0);
    rst = 1'b1;
    #1;
    check("abort C", 32'(bus.C), 32'd0);
    check("abort state", 32'(dut.state), 32'(LOAD));
    mult(4'b0011, 4'b0011, 8'd9, "restart 3x3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
